// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate cache with word-serial line refill.
// Defining DCACHE_PERF_EN adds saturating load hit/miss counters (hit_cnt_o, miss_cnt_o).
module data_cache #(
    parameter int WIDTH      = 32,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] adr_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_adr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic             mem_ack_i
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]      hit_cnt_o,
    output logic [31:0]      miss_cnt_o
`endif
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = WIDTH - 4 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    state_t state;
    state_t state_next;
    logic [1:0] beat;
    logic [1:0] beat_next;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [WIDTH-1:0] data_mem [SETS][LINE_WORDS];

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    logic fill_we;
    logic fill_done;
    logic store_we;

    logic unused_adr_bits;

    assign offset          = adr_i[3:2];
    assign index           = adr_i[4 +: INDEX_W];
    assign tag             = adr_i[WIDTH-1 -: TAG_W];
    assign hit             = valid[index] && (tag_mem[index] == tag);
    assign unused_adr_bits = ^adr_i[1:0];

    // Lookup, refill sequencing and write-through; stores take priority over loads.
    always_comb begin
        state_next  = state;
        beat_next   = beat;
        stall_o     = 1'b0;
        read_data_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_adr_o   = '0;
        mem_wdata_o = '0;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        store_we    = 1'b0;

        case (state)
            IDLE: begin
                if (mem_write_i) begin
                    stall_o    = 1'b1;
                    state_next = WRITE;
                end else if (mem_read_i) begin
                    if (hit) begin
                        read_data_o = data_mem[index][offset];
                    end else begin
                        stall_o    = 1'b1;
                        beat_next  = 2'd0;
                        state_next = REFILL;
                    end
                end
            end

            REFILL: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                mem_adr_o = {adr_i[WIDTH-1:4], beat, 2'b00};
                if (mem_ack_i) begin
                    fill_we   = 1'b1;
                    beat_next = beat + 2'd1;
                    if (beat == 2'd3) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            WRITE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_adr_o   = {adr_i[WIDTH-1:2], 2'b00};
                mem_wdata_o = write_data_i;
                // Releasing stall in the ack cycle lets the pipeline advance on this edge.
                stall_o     = !mem_ack_i;
                if (mem_ack_i) begin
                    store_we   = hit;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= 2'd0;
            valid <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (fill_done) begin
                valid[index] <= 1'b1;
            end
        end
    end

    // Arrays carry no reset; a line abandoned by reset stays invalid via valid[].
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (fill_we) begin
                data_mem[index][beat] <= mem_rdata_i;
            end
            if (fill_done) begin
                tag_mem[index] <= tag;
            end
            if (store_we) begin
                data_mem[index][offset] <= write_data_i;
            end
        end
    end

`ifdef DCACHE_PERF_EN
    logic after_refill;

    // The hit that completes a refilled load is not a first-lookup hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
            after_refill <= 1'b0;
        end else begin
            after_refill <= fill_done;
            if (state == IDLE && mem_read_i && !mem_write_i) begin
                if (hit && !after_refill && hit_cnt_o != 32'hFFFF_FFFF) begin
                    hit_cnt_o <= hit_cnt_o + 32'd1;
                end
                if (!hit && miss_cnt_o != 32'hFFFF_FFFF) begin
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache; a backing-memory responder with programmable
// ack delay checks every request against queued expectations, load tasks check data and stall counts.
module tb_data_cache;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] adr_i;
    logic [WIDTH-1:0] write_data_i;
    logic             mem_read_i;
    logic             mem_write_i;
    logic [WIDTH-1:0] read_data_o;
    logic             stall_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [WIDTH-1:0] mem_adr_o;
    logic [WIDTH-1:0] mem_wdata_o;
    logic [WIDTH-1:0] mem_rdata_i;
    logic             mem_ack_i;
`ifdef DCACHE_PERF_EN
    logic [31:0]      hit_cnt_o;
    logic [31:0]      miss_cnt_o;
`endif

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    int          checks    = 0;
    int          errors    = 0;
    int          ack_delay = 0;
    int          ack_count = 0;
    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] mem_model [logic [31:0]];

    data_cache #(.WIDTH(WIDTH), .SETS(256), .LINE_WORDS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adr_i        (adr_i),
        .write_data_i (write_data_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .read_data_o  (read_data_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_adr_o    (mem_adr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_PERF_EN
        ,
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Backing memory: acks after ack_delay waiting cycles and pops the expected request.
    initial begin : responder
        int          wait_cnt;
        logic        hold_valid;
        logic [31:0] hold_adr;
        req_t        exp;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        wait_cnt    = 0;
        hold_valid  = 1'b0;
        hold_adr    = '0;
        forever begin
            @(negedge clk);
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            if (!mem_req_o) begin
                wait_cnt   = 0;
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    checks++;
                    if (mem_adr_o !== hold_adr) begin
                        errors++;
                        $display("[TB] FAIL adr_stable: got %h expected %h", mem_adr_o, hold_adr);
                    end
                end
                hold_adr   = mem_adr_o;
                hold_valid = 1'b1;
                if (wait_cnt >= ack_delay) begin
                    mem_ack_i  = 1'b1;
                    ack_count++;
                    wait_cnt   = 0;
                    hold_valid = 1'b0;
                    if (mem_we_o) mem_model[mem_adr_o] = mem_wdata_o;
                    else          mem_rdata_i = model_read(mem_adr_o);
                    checks++;
                    if (exp_req_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_req: got adr %h we %b, expected none", mem_adr_o, mem_we_o);
                    end else begin
                        exp = exp_req_q.pop_front();
                        if (mem_adr_o !== exp.adr || mem_we_o !== exp.we ||
                            (exp.we && mem_wdata_o !== exp.wdata)) begin
                            errors++;
                            $display("[TB] FAIL mem_req: got adr %h we %b wdata %h, expected adr %h we %b wdata %h",
                                     mem_adr_o, mem_we_o, mem_wdata_o, exp.adr, exp.we, exp.wdata);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic push_refill(input logic [31:0] base);
        for (int b = 0; b < 4; b++) begin
            exp_req_q.push_back('{adr: base + 32'(b * 4), we: 1'b0, wdata: 32'h0});
        end
    endtask

    task automatic drive_load(input logic [31:0] a, output logic [31:0] data, output int stalls);
        @(posedge clk); #1;
        adr_i        = a;
        write_data_i = '0;
        mem_read_i   = 1'b1;
        mem_write_i  = 1'b0;
        stalls       = 0;
        data         = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #2;
            if (!stall_o) begin
                data = read_data_o;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        mem_read_i = 1'b0;
        adr_i      = '0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] wd, output int stalls);
        @(posedge clk); #1;
        adr_i        = a;
        write_data_i = wd;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b1;
        stalls       = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #2;
            if (!stall_o) break;
            stalls++;
        end
        @(posedge clk); #1;
        mem_write_i  = 1'b0;
        adr_i        = '0;
        write_data_i = '0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        adr_i        = '0;
        write_data_i = '0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got stall %b req %b we %b, expected 0 0 0", stall_o, mem_req_o, mem_we_o);
        end
        checks++;
        if (mem_adr_o !== 32'h0 || mem_wdata_o !== 32'h0 || read_data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got adr %h wdata %h rdata %h, expected all 0", mem_adr_o, mem_wdata_o, read_data_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_miss();
        logic [31:0] d;
        logic [31:0] exp;
        int          s;
        push_refill(32'h100);
        exp_rd_q.push_back(model_read(32'h100));
        drive_load(32'h100, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("[TB] FAIL miss_data_100: got %h expected %h", d, exp); end
        checks++;
        if (s != 5) begin errors++; $display("[TB] FAIL miss_stalls_100: got %0d expected 5", s); end
        exp_rd_q.push_back(model_read(32'h108));
        drive_load(32'h108, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("[TB] FAIL hit_data_108: got %h expected %h", d, exp); end
        checks++;
        if (s != 0) begin errors++; $display("[TB] FAIL hit_stalls_108: got %0d expected 0", s); end
    endtask

    task automatic test_store_hit();
        logic [31:0] d;
        logic [31:0] exp;
        int          s;
        exp_req_q.push_back('{adr: 32'h104, we: 1'b1, wdata: 32'hDEAD_BEEF});
        drive_store(32'h104, 32'hDEAD_BEEF, s);
        checks++;
        if (s != 1) begin errors++; $display("[TB] FAIL store_stalls_104: got %0d expected 1", s); end
        exp_rd_q.push_back(32'hDEAD_BEEF);
        drive_load(32'h104, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("[TB] FAIL store_hit_data_104: got %h expected %h", d, exp); end
        checks++;
        if (s != 0) begin errors++; $display("[TB] FAIL store_hit_stalls_104: got %0d expected 0", s); end
    endtask

    task automatic test_store_miss();
        logic [31:0] d;
        logic [31:0] exp;
        int          s;
        exp_req_q.push_back('{adr: 32'h2000, we: 1'b1, wdata: 32'h1234_5678});
        drive_store(32'h2000, 32'h1234_5678, s);
        checks++;
        if (s != 1) begin errors++; $display("[TB] FAIL store_stalls_2000: got %0d expected 1", s); end
        push_refill(32'h2000);
        exp_rd_q.push_back(32'h1234_5678);
        drive_load(32'h2000, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("[TB] FAIL no_alloc_data_2000: got %h expected %h", d, exp); end
        checks++;
        if (s != 5) begin errors++; $display("[TB] FAIL no_alloc_stalls_2000: got %0d expected 5", s); end
    endtask

    task automatic test_conflict();
        logic [31:0] d;
        logic [31:0] exp;
        int          s;
        exp_rd_q.push_back(model_read(32'h100));
        drive_load(32'h100, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp || s != 0) begin
            errors++;
            $display("[TB] FAIL conflict_prehit_100: got %h/%0d expected %h/0", d, s, exp);
        end
        push_refill(32'h1100);
        exp_rd_q.push_back(model_read(32'h1100));
        drive_load(32'h1100, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp || s != 5) begin
            errors++;
            $display("[TB] FAIL conflict_evict_1100: got %h/%0d expected %h/5", d, s, exp);
        end
        push_refill(32'h100);
        exp_rd_q.push_back(model_read(32'h100));
        drive_load(32'h100, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp || s != 5) begin
            errors++;
            $display("[TB] FAIL conflict_remiss_100: got %h/%0d expected %h/5", d, s, exp);
        end
        exp_rd_q.push_back(32'hDEAD_BEEF);
        drive_load(32'h104, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp || s != 0) begin
            errors++;
            $display("[TB] FAIL conflict_hit_104: got %h/%0d expected %h/0", d, s, exp);
        end
    endtask

    task automatic test_slow_refill();
        logic [31:0] d;
        logic [31:0] exp;
        logic [31:0] a;
        int          s;
        ack_delay = 3;
        push_refill(32'h4000);
        exp_rd_q.push_back(model_read(32'h4000));
        drive_load(32'h4000, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("[TB] FAIL slow_data_4000: got %h expected %h", d, exp); end
        checks++;
        if (s != 17) begin errors++; $display("[TB] FAIL slow_stalls_4000: got %0d expected 17", s); end
        for (int w = 3; w >= 1; w--) begin
            a = 32'h4000 + 32'(w * 4);
            exp_rd_q.push_back(model_read(a));
            drive_load(a, d, s);
            exp = exp_rd_q.pop_front();
            checks++;
            if (d !== exp || s != 0) begin
                errors++;
                $display("[TB] FAIL slow_word_%h: got %h/%0d expected %h/0", a, d, s, exp);
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d;
        logic [31:0] exp;
        int          s;
        int          start;
        bit          reached;
        exp_req_q.push_back('{adr: 32'h3000, we: 1'b0, wdata: 32'h0});
        exp_req_q.push_back('{adr: 32'h3004, we: 1'b0, wdata: 32'h0});
        start   = ack_count;
        reached = 1'b0;
        @(posedge clk); #1;
        adr_i      = 32'h3000;
        mem_read_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (ack_count >= start + 2) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin errors++; $display("[TB] FAIL midreset_beats: got %0d acks expected 2", ack_count - start); end
        rst_n      = 1'b0;
        mem_read_i = 1'b0;
        adr_i      = '0;
        @(posedge clk); #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_idle: got req %b stall %b expected 0 0", mem_req_o, stall_o);
        end
        rst_n = 1'b1;
        push_refill(32'h3000);
        exp_rd_q.push_back(model_read(32'h3000));
        drive_load(32'h3000, d, s);
        exp = exp_rd_q.pop_front();
        checks++;
        if (d !== exp || s != 5) begin
            errors++;
            $display("[TB] FAIL midreset_reload: got %h/%0d expected %h/5", d, s, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_load_miss();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_slow_refill();
        test_reset_mid_refill();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_req_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_reqs: got %0d outstanding expected 0", exp_req_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
